// File: rtl/abuf_pingpong_pkg.sv
// Shared definitions for the activation reuse buffer: default geometry and
// the runtime configuration record (row length, replays per row).
package abuf_pingpong_pkg;

  localparam int MAC_MULT_NUM = 16;
  localparam int IDATA_WIDTH  = 8;
  localparam int ABUF_DATA_W  = MAC_MULT_NUM * IDATA_WIDTH;
  localparam int ABUF_DEPTH   = 64;
  localparam int ABUF_ITER_W  = 8;
  localparam int ABUF_LEN_W   = $clog2(ABUF_DEPTH) + 1;

  typedef struct packed {
    logic [ABUF_LEN_W-1:0]  row_len;
    logic [ABUF_ITER_W-1:0] reuse_cnt;
  } abuf_cfg_t;

endpackage

// File: rtl/abuf_bank.sv
// One activation bank: DEPTH x DATA_W registers, synchronous write,
// combinational read. Contents are deliberately not reset.
module abuf_bank #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 64,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/abuf_pingpong.sv
// Ping-pong activation reuse buffer: captures a row into one bank while the
// other bank's row is replayed reuse_cnt times through a ready/valid output.
//
// Handshakes: a word moves on either side exactly in a cycle where valid and
// ready are both high at the clock edge; valid never depends on ready, and
// while out_vld is high without out_rdy, out_data and the flags hold.
module abuf_pingpong
  import abuf_pingpong_pkg::*;
#(
  parameter int DATA_W = ABUF_DATA_W,
  parameter int DEPTH  = ABUF_DEPTH,
  parameter int ITER_W = ABUF_ITER_W,
  parameter int LEN_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_vld,
  input  logic [LEN_W-1:0]  cfg_row_len,
  input  logic [ITER_W-1:0] cfg_reuse_cnt,
  output logic              cfg_err,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_vld,
  output logic              in_rdy,
  output logic [DATA_W-1:0] out_data,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic              out_last_word,
  output logic              out_last_row,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH);

  logic [LEN_W-1:0]  row_len;
  logic [ITER_W-1:0] reuse_cnt;
  logic [1:0]        full, full_nxt;
  logic              wr_bank, rd_bank;
  logic [LEN_W-1:0]  wr_ptr, rd_ptr;
  logic [ITER_W-1:0] iter;
  logic [DATA_W-1:0] rdata0, rdata1, rd_word;

  logic wr_fire, wr_last, rd_load, rd_last_word, rd_release;
  logic cfg_ok, cfg_take;

  assign in_rdy  = ~full[wr_bank];
  assign busy    = (|full) | out_vld;
  assign wr_fire = in_vld & in_rdy & ~flush;
  assign wr_last = (wr_ptr == row_len - LEN_W'(1));

  assign rd_load      = (~out_vld | out_rdy) & full[rd_bank] & ~flush;
  assign rd_last_word = (rd_ptr == row_len - LEN_W'(1));
  assign rd_release   = rd_last_word & (iter == reuse_cnt - ITER_W'(1));
  assign rd_word      = rd_bank ? rdata1 : rdata0;

  assign cfg_ok   = (cfg_row_len != '0) && (cfg_row_len <= LEN_W'(DEPTH)) &&
                    (cfg_reuse_cnt != '0);
  assign cfg_take = cfg_vld & ~busy & (wr_ptr == '0) & cfg_ok;

  // The writer only targets an empty bank and the reader only a full one,
  // so set and clear can never hit the same bank in one cycle.
  always_comb begin
    full_nxt = full;
    if (wr_fire && wr_last) full_nxt[wr_bank] = 1'b1;
    if (rd_load && rd_release) full_nxt[rd_bank] = 1'b0;
  end

  abuf_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_bank0 (
    .clk(clk), .we(wr_fire & ~wr_bank), .waddr(wr_ptr[AW-1:0]),
    .wdata(in_data), .raddr(rd_ptr[AW-1:0]), .rdata(rdata0)
  );

  abuf_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_bank1 (
    .clk(clk), .we(wr_fire & wr_bank), .waddr(wr_ptr[AW-1:0]),
    .wdata(in_data), .raddr(rd_ptr[AW-1:0]), .rdata(rdata1)
  );

  // Configuration survives flush; only reset restores the 1x1 default.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_len   <= LEN_W'(1);
      reuse_cnt <= ITER_W'(1);
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= cfg_vld & ~cfg_take;
      if (cfg_take) begin
        row_len   <= cfg_row_len;
        reuse_cnt <= cfg_reuse_cnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full          <= '0;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      iter          <= '0;
      out_data      <= '0;
      out_vld       <= 1'b0;
      out_last_word <= 1'b0;
      out_last_row  <= 1'b0;
    end else if (flush) begin
      full          <= '0;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      iter          <= '0;
      out_vld       <= 1'b0;
      out_last_word <= 1'b0;
      out_last_row  <= 1'b0;
    end else begin
      full <= full_nxt;
      if (wr_fire) begin
        wr_ptr <= wr_last ? '0 : wr_ptr + LEN_W'(1);
        if (wr_last) wr_bank <= ~wr_bank;
      end
      if (rd_load) begin
        rd_ptr        <= rd_last_word ? '0 : rd_ptr + LEN_W'(1);
        out_data      <= rd_word;
        out_vld       <= 1'b1;
        out_last_word <= rd_last_word;
        out_last_row  <= rd_release;
        if (rd_release) begin
          iter    <= '0;
          rd_bank <= ~rd_bank;
        end else if (rd_last_word) begin
          iter <= iter + ITER_W'(1);
        end
      end else if (out_rdy) begin
        out_vld       <= 1'b0;
        out_last_word <= 1'b0;
        out_last_row  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/abuf_pingpong.md
Name: abuf_pingpong

Overview:
- Parametrised activation reuse buffer: next generation of the head-core activation buffer.
- Captures one activation row (ROW_LEN words of MAC_MULT_NUM×IDATA_WIDTH bits) and replays it REUSE_CNT times to the MAC array.
- Two banks (ping-pong), so row N+1 loads while row N is still being replayed.
- Adds ready/valid backpressure on both sides and a runtime row-length/reuse configuration. The upstream controller maps control_state to cfg.

Parameters:
- DATA_W, `MAC_MULT_NUM*`IDATA_WIDTH (128): word width.
- DEPTH, 64: words per bank. Maximum row length.
- ITER_W, 8: reuse counter width. Maximum reuse is 2^ITER_W-1.
- LEN_W, $clog2(DEPTH)+1: row-length field width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_vld  in  1  config strobe.
- cfg_row_len  in  LEN_W  words per row, legal range 1..DEPTH.
- cfg_reuse_cnt  in  ITER_W  replays per row, legal range ≥1.
- cfg_err  out  1  one-cycle pulse: config rejected.
- flush  in  1  synchronous abort of all rows in flight.
- in_data  in  DATA_W  input word.
- in_vld  in  1  input valid.
- in_rdy  out  1  input ready.
- out_data  out  DATA_W  output word.
- out_vld  out  1  output valid.
- out_rdy  in  1  downstream ready.
- out_last_word  out  1  marks the last word of each replay.
- out_last_row  out  1  marks the last word of the last replay (finish_row).
- busy  out  1  any bank full, or out_vld high.

Behaviour:
- Single clock domain; reset is asynchronous, active-low.
- Reset state:
  - out_data=0, out_vld=0, out_last_word=0, out_last_row=0, cfg_err=0, busy=0.
  - in_rdy=1.
  - Configuration registers reset to row_len=1, reuse=1.
  - Bank contents are not reset.
- Config:
  - Accepted on cfg_vld only when busy=0 and no write is in progress (wr_ptr=0).
  - Rejected with a cfg_err pulse on the next cycle, old config kept, if:
    - busy, or
    - cfg_row_len is 0 or greater than DEPTH, or
    - cfg_reuse_cnt is 0.
- Write side:
  - Handshake fires when in_vld & in_rdy.
  - in_rdy = ~full[wr_bank], derived from registers only.
  - Each handshake writes bank[wr_bank][wr_ptr] and increments wr_ptr.
  - When wr_ptr=row_len-1 is written: wr_ptr←0, full[wr_bank]←1, wr_bank toggles.
- Read side:
  - The output register loads when (~out_vld | out_rdy) & full[rd_bank].
  - Each load takes bank[rd_bank][rd_ptr].
  - rd_ptr increments; at row_len-1 it wraps to 0 and iter increments.
  - At iter=reuse-1 with rd_ptr=row_len-1:
    - iter←0, full[rd_bank]←0, rd_bank toggles;
    - out_last_row is loaded high with this word.
  - out_last_word is loaded high whenever rd_ptr=row_len-1.
  - If no load occurs and out_rdy=1, out_vld←0.
  - While out_vld & ~out_rdy, out_data and both flags hold stable.
- Latency and throughput:
  - If the last input handshake of a row is in cycle n, out_vld first rises in cycle n+2 (read side idle).
  - Throughput is 1 word/cycle with out_rdy held high.
  - Back-to-back rows: no bubble if the other bank is already full when a row releases.
- Simultaneous events:
  - Write-complete on one bank and read-release on the other in the same cycle: both take effect.
  - A bank released in cycle n is writable (in_rdy=1) from cycle n+1.
- Flush:
  - Next edge: full[1:0]←0, all pointers/iter/bank selects←0, out_vld and flags←0.
  - cfg is retained.
  - flush has priority over any concurrent handshake.
- Reset mid-operation returns immediately to the reset state; no partial row survives.
- Counter widths must not overflow at row_len=DEPTH or reuse=2^ITER_W-1.

Decomposition:
- Shared package (head package, alongside CONTROL_STATE and MODEL_CONFIG):
  - typedef abuf_cfg_t {row_len, reuse_cnt};
  - DEPTH and ITER_W default localparams.
- Sub-module abuf_bank:
  - one DEPTH×DATA_W register bank;
  - synchronous write port, combinational read port;
  - instantiated twice.
- Pointer/flag control and the output register stay in abuf_pingpong.

Test Plan:
- Reset checks:
  - Stimulus: assert rst_n=0 mid-stream, then release.
  - Required: all outputs at reset values within the same cycle; in_rdy=1; a subsequent row streams correctly.
- Basic reuse:
  - Stimulus: row_len=4, reuse=3, inputs A0..A3, out_rdy=1.
  - Required: 12 outputs A0..A3 ×3; out_last_word on words 4, 8, 12; out_last_row only on word 12; first out_vld 2 cycles after A3.
- Ping-pong:
  - Stimulus: same config, rows A and B, then C offered immediately.
  - Required: 24 consecutive out_vld cycles with no bubble; in_rdy low once both banks are full, high again the cycle after A releases; C then follows B.
- Backpressure:
  - Stimulus: row_len=8, reuse=2, out_rdy pseudo-random at 50%.
  - Required: sequence identical to the out_rdy=1 case; out_data stable whenever out_vld & ~out_rdy.
- Boundary and config:
  - Stimulus: row_len=64, reuse=1.
  - Required: 64 outputs with out_last_row on the 64th; pointer wraps cleanly.
  - Stimulus: cfg with row_len=0, or any cfg while busy.
  - Required: cfg_err pulses once; behaviour unchanged.
- Flush:
  - Stimulus: flush after 5 outputs of a 4×3 row.
  - Required: out_vld=0 and in_rdy=1 next cycle; a new row D0..D3 replays 3 times correctly.
